// File: rtl/pc_frame_return_unit_pkg.sv
// Frame constants and types shared by the return-frame reader and the
// execute-memory push path, so both sides agree on the layout.
// Frame layout: the high word is pushed first, so it sits at the higher address.
// The low word sits at the next lower address.
// The {C,N,Z} flags live in the high word starting at FRAME_FLAG_LSB.
package pc_frame_return_unit_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        POP_LO   = 2'd1,
        POP_HI   = 2'd2,
        REDIRECT = 2'd3
    } frame_state_e;

    // Lowest flag bit position within the high frame word.
    localparam int FRAME_FLAG_LSB = 13;

    // Flag field width and ordering {C,N,Z}, MSB first.
    localparam int FLAG_W     = 3;
    localparam int FLAG_C_OFS = 2;
    localparam int FLAG_N_OFS = 1;
    localparam int FLAG_Z_OFS = 0;

    // Word order: two words per frame, high word pushed first.
    localparam int FRAME_WORDS    = 2;
    localparam bit FRAME_HI_FIRST = 1'b1;

    typedef struct packed {
        logic c;
        logic n;
        logic z;
    } frame_flags_t;

endpackage

// File: rtl/pc_frame_return_unit_if.sv
// Execute-memory side bus of the return-frame reader: request pulses,
// data-memory read path, and the redirect / flag-restore results.
interface pc_frame_return_unit_if
    import pc_frame_return_unit_pkg::*;
#(
    parameter int DATA_W = 16
);
    logic                  i_ret;
    logic                  i_rti;
    logic                  i_hold;
    logic [DATA_W-1:0]     i_mem_data;
    logic                  o_pop;
    logic                  o_mem_read;
    logic                  o_stall;
    logic                  o_busy;
    logic                  o_pc_valid;
    logic [2*DATA_W-1:0]   o_pc_new;
    logic                  o_flags_valid;
    logic [FLAG_W-1:0]     o_flags;

    // Unit side
    modport slave (
        input  i_ret, i_rti, i_hold, i_mem_data,
        output o_pop, o_mem_read, o_stall, o_busy,
               o_pc_valid, o_pc_new, o_flags_valid, o_flags
    );

    // Pipeline side
    modport master (
        output i_ret, i_rti, i_hold, i_mem_data,
        input  o_pop, o_mem_read, o_stall, o_busy,
               o_pc_valid, o_pc_new, o_flags_valid, o_flags
    );
endinterface

// File: rtl/pc_frame_return_unit.sv
// Return-frame reader.
// It pops the low then the high PC word and rebuilds the return PC.
// It issues a one-cycle redirect strobe.
// Optional macro PC_FRAME_FLAG_RESTORE_EN: RTI also restores {C,N,Z} from the
// high word and masks those bits out of the returned PC.
// Without the macro, RTI behaves as RET.
module pc_frame_return_unit
    import pc_frame_return_unit_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int FLAG_LSB = FRAME_FLAG_LSB
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    pc_frame_return_unit_if.slave  bus
);

    if (FLAG_LSB + FLAG_W > DATA_W) begin : g_bad_flag_lsb
        $error("FLAG_LSB leaves no room for the flag field in the high word");
    end

    frame_state_e       state_q;
    logic [DATA_W-1:0]  lo_q;       // low word captured in POP_LO
    logic [DATA_W-1:0]  hi_q;       // high PC half as presented on o_pc_new
    logic [DATA_W-1:0]  pc_lo_q;    // low PC half as presented on o_pc_new
    logic               pc_valid_q;
    logic               popping;

`ifdef PC_FRAME_FLAG_RESTORE_EN
    localparam logic [DATA_W-1:0] HI_PC_MASK =
        {{(DATA_W-FLAG_LSB){1'b0}}, {FLAG_LSB{1'b1}}};

    logic          is_rti_q;
    logic          flags_valid_q;
    frame_flags_t  flags_q;
`endif

    // Frame sequencer: the request latches the frame type, then two pops with hold backpressure, then one redirect cycle
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q       <= IDLE;
            lo_q          <= '0;
            hi_q          <= '0;
            pc_lo_q       <= '0;
            pc_valid_q    <= 1'b0;
`ifdef PC_FRAME_FLAG_RESTORE_EN
            is_rti_q      <= 1'b0;
            flags_valid_q <= 1'b0;
            flags_q       <= '0;
`endif
        end else begin
            pc_valid_q    <= 1'b0;
`ifdef PC_FRAME_FLAG_RESTORE_EN
            flags_valid_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (bus.i_ret || bus.i_rti) begin
`ifdef PC_FRAME_FLAG_RESTORE_EN
                        is_rti_q <= bus.i_rti;
`endif
                        state_q  <= POP_LO;
                    end
                end
                POP_LO: begin
                    if (!bus.i_hold) begin
                        lo_q    <= bus.i_mem_data;
                        state_q <= POP_HI;
                    end
                end
                POP_HI: begin
                    if (!bus.i_hold) begin
                        pc_lo_q    <= lo_q;
                        pc_valid_q <= 1'b1;
                        state_q    <= REDIRECT;
`ifdef PC_FRAME_FLAG_RESTORE_EN
                        if (is_rti_q) begin
                            hi_q          <= bus.i_mem_data & HI_PC_MASK;
                            flags_q       <= frame_flags_t'(bus.i_mem_data[FLAG_LSB +: FLAG_W]);
                            flags_valid_q <= 1'b1;
                        end else begin
                            hi_q          <= bus.i_mem_data;
                        end
`else
                        hi_q       <= bus.i_mem_data;
`endif
                    end
                end
                REDIRECT: state_q <= IDLE;
                default:  state_q <= IDLE;
            endcase
        end
    end

    // Pop and read are gated combinationally by hold, so a held cycle never moves SP
    assign popping        = (state_q == POP_LO) || (state_q == POP_HI);
    assign bus.o_pop      = popping && !bus.i_hold;
    assign bus.o_mem_read = popping && !bus.i_hold;
    assign bus.o_busy     = (state_q != IDLE);
    // Request cycle stalls too; gated by reset so every output is low while reset is held
    assign bus.o_stall    = i_reset && (bus.o_busy || bus.i_ret || bus.i_rti);
    assign bus.o_pc_valid = pc_valid_q;
    assign bus.o_pc_new   = {hi_q, pc_lo_q};

`ifdef PC_FRAME_FLAG_RESTORE_EN
    assign bus.o_flags_valid = flags_valid_q;
    assign bus.o_flags       = flags_q;
`else
    assign bus.o_flags_valid = 1'b0;
    assign bus.o_flags       = '0;
`endif

endmodule

// File: tb/tb_pc_frame_return_unit.sv
// Directed bench for pc_frame_return_unit: table of frame sequences with
// per-cycle pop/strobe checks, plus a mid-sequence reset sequence.
module tb_pc_frame_return_unit;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_bad;

    pc_frame_return_unit_if #(.DATA_W(16)) bus ();

    pc_frame_return_unit #(.DATA_W(16), .FLAG_LSB(13)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ret;
        logic        rti;
        logic        xret;   // extra i_ret pulse in the POP_HI pop cycle
        logic [15:0] lo;
        logic [15:0] hi;
        int          h1;     // hold cycles before the low pop
        int          h2;     // hold cycles before the high pop
        logic [31:0] pc;
        logic        fv;
        logic [2:0]  fl;
    } vec_t;

    vec_t vt [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int  total;
        int  pops;
        logic ep;
        @(negedge clk);
        bus.i_ret = v.ret; bus.i_rti = v.rti; bus.i_hold = 1'b0; bus.i_mem_data = 16'hDEAD;
        #1;
        chk($sformatf("v%0d stall_T0", idx), 32'(bus.o_stall), 32'd1);
        chk($sformatf("v%0d busy_T0", idx), 32'(bus.o_busy), 32'd0);
        total = 3 + v.h1 + v.h2;
        pops  = 0;
        for (int c = 1; c <= total; c++) begin
            @(negedge clk);
            bus.i_ret = 1'b0; bus.i_rti = 1'b0; ep = 1'b0;
            if (c <= v.h1) begin
                bus.i_hold = 1'b1; bus.i_mem_data = 16'($urandom);
            end else if (c == v.h1 + 1) begin
                bus.i_hold = 1'b0; bus.i_mem_data = v.lo; ep = 1'b1;
            end else if (c <= v.h1 + 1 + v.h2) begin
                bus.i_hold = 1'b1; bus.i_mem_data = 16'($urandom);
            end else if (c == v.h1 + v.h2 + 2) begin
                bus.i_hold = 1'b0; bus.i_mem_data = v.hi; ep = 1'b1;
                if (v.xret) bus.i_ret = 1'b1;
            end else begin
                bus.i_hold = 1'b0; bus.i_mem_data = 16'($urandom);
            end
            #1;
            chk($sformatf("v%0d pop_T%0d", idx, c), 32'(bus.o_pop), 32'(ep));
            chk($sformatf("v%0d mem_read_T%0d", idx, c), 32'(bus.o_mem_read), 32'(ep));
            chk($sformatf("v%0d stall_T%0d", idx, c), 32'(bus.o_stall), 32'd1);
            chk($sformatf("v%0d pc_valid_T%0d", idx, c), 32'(bus.o_pc_valid), 32'(c == total));
            if (bus.o_pop) pops++;
            if (c == total) begin
                chk($sformatf("v%0d pc_new", idx), bus.o_pc_new, v.pc);
                chk($sformatf("v%0d flags_valid", idx), 32'(bus.o_flags_valid), 32'(v.fv));
                if (v.fv) chk($sformatf("v%0d flags", idx), 32'(bus.o_flags), 32'(v.fl));
            end
        end
        chk($sformatf("v%0d pop_count", idx), 32'(pops), 32'd2);
        @(negedge clk);
        bus.i_ret = 1'b0; bus.i_rti = 1'b0; bus.i_hold = 1'b0;
        #1;
        chk($sformatf("v%0d pc_valid_after", idx), 32'(bus.o_pc_valid), 32'd0);
        chk($sformatf("v%0d busy_after", idx), 32'(bus.o_busy), 32'd0);
        chk($sformatf("v%0d stall_after", idx), 32'(bus.o_stall), 32'd0);
        chk($sformatf("v%0d pc_hold_after", idx), bus.o_pc_new, v.pc);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;

        //        ret   rti   xret  lo        hi        h1 h2  pc             fv    fl
        vt[0] = '{1'b1, 1'b0, 1'b0, 16'h1234, 16'h0001, 0, 0, 32'h0001_1234, 1'b0, 3'b000};
`ifdef PC_FRAME_FLAG_RESTORE_EN
        vt[1] = '{1'b0, 1'b1, 1'b0, 16'h0100, 16'hA005, 0, 0, 32'h0005_0100, 1'b1, 3'b101};
        vt[3] = '{1'b1, 1'b1, 1'b1, 16'h5678, 16'hE123, 0, 0, 32'h0123_5678, 1'b1, 3'b111};
        vt[4] = '{1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h3FFF, 1, 1, 32'h1FFF_FFFF, 1'b1, 3'b001};
`else
        vt[1] = '{1'b0, 1'b1, 1'b0, 16'h0100, 16'hA005, 0, 0, 32'hA005_0100, 1'b0, 3'b000};
        vt[3] = '{1'b1, 1'b1, 1'b1, 16'h5678, 16'hE123, 0, 0, 32'hE123_5678, 1'b0, 3'b000};
        vt[4] = '{1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h3FFF, 1, 1, 32'h3FFF_FFFF, 1'b0, 3'b000};
`endif
        vt[2] = '{1'b1, 1'b0, 1'b0, 16'hBEEF, 16'h0042, 2, 0, 32'h0042_BEEF, 1'b0, 3'b000};
        vt[5] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 0, 2, 32'hFFFF_0000, 1'b0, 3'b000};

        rst_n = 1'b0;
        bus.i_ret = 1'b0; bus.i_rti = 1'b0; bus.i_hold = 1'b0; bus.i_mem_data = '0;
        #12;
        chk("reset busy", 32'(bus.o_busy), 32'd0);
        chk("reset stall", 32'(bus.o_stall), 32'd0);
        chk("reset pop", 32'(bus.o_pop), 32'd0);
        chk("reset pc_valid", 32'(bus.o_pc_valid), 32'd0);
        chk("reset pc_new", bus.o_pc_new, 32'd0);
        chk("reset flags", 32'({bus.o_flags_valid, bus.o_flags}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vt[i], i);

        // Reset asserted during POP_HI: everything drops at once, no redirect follows
        run_vec(vt[0], 10);
        @(negedge clk);
        bus.i_ret = 1'b1;
        @(negedge clk);
        bus.i_ret = 1'b0; bus.i_mem_data = 16'h1111;
        @(negedge clk);
        bus.i_mem_data = 16'h2222;
        #1;
        chk("pre_reset pop_hi", 32'(bus.o_pop), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst pop", 32'(bus.o_pop), 32'd0);
        chk("midrst mem_read", 32'(bus.o_mem_read), 32'd0);
        chk("midrst busy", 32'(bus.o_busy), 32'd0);
        chk("midrst stall", 32'(bus.o_stall), 32'd0);
        chk("midrst pc_valid", 32'(bus.o_pc_valid), 32'd0);
        chk("midrst pc_new", bus.o_pc_new, 32'd0);
        chk("midrst flags", 32'({bus.o_flags_valid, bus.o_flags}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("postrst busy", 32'(bus.o_busy), 32'd0);
        chk("postrst pc_valid", 32'(bus.o_pc_valid), 32'd0);
        run_vec('{1'b1, 1'b0, 1'b0, 16'hC0DE, 16'h0777, 0, 0, 32'h0777_C0DE, 1'b0, 3'b000}, 11);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Global watchdog so the run always ends on its own
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pc_frame_return_unit.md
# pc_frame_return_unit

Stack-frame reader for return instructions. It pops the two-word PC frame that CALL/INT pushes in the execute-memory stage, reassembles the 32-bit return PC, optionally restores the C/N/Z flags, and redirects fetch. It sits beside the execute-memory stage and owns the stack/memory-read controls for the frame's duration. It stalls the front end until the redirect is issued.

## Interface
- `DATA_W`, default 16: data memory word width. The PC is 2*DATA_W.
- `FLAG_LSB`, default 13: bit position of the lowest flag bit within the high frame word.
- `i_clk`, in, 1: clock, rising edge.
- `i_reset`, in, 1: asynchronous, active-low reset.
- `i_ret`, in, 1: RET issued by the execute-memory stage, one-cycle pulse.
- `i_rti`, in, 1: RTI issued, one-cycle pulse.
- `i_hold`, in, 1: data memory port busy with an older access; the unit must not pop this cycle.
- `i_mem_data`, in, DATA_W: data memory read data, valid in the same cycle as the read.
- `o_pop`, out, 1: stack operation enable with function=pop (SP += 1).
- `o_mem_read`, out, 1: data memory read enable.
- `o_stall`, out, 1: freeze fetch/decode.
- `o_busy`, out, 1: a frame sequence is in progress.
- `o_pc_valid`, out, 1: one-cycle redirect strobe.
- `o_pc_new`, out, 2*DATA_W: return PC.
- `o_flags_valid`, out, 1: one-cycle flag-restore strobe.
- `o_flags`, out, 3: restored {C,N,Z}.

## Operation
- Frame layout, pushed high-first (SP decrements):
  - High word at the higher address. Bits [DATA_W-1:FLAG_LSB] hold {C,N,Z} for interrupt frames.
  - Low word at the next lower address.
  - The unit therefore pops low first, then high.
- States:
  - IDLE: on `i_ret|i_rti`, latch `is_rti` (RTI wins if both are high) and go to POP_LO.
  - POP_LO: `o_pop=o_mem_read=~i_hold`. When `~i_hold`, capture `i_mem_data` into `lo_q` at the edge and go to POP_HI. When `i_hold`, stay in POP_LO.
  - POP_HI: same rule; capture into `hi_q`, then go to REDIRECT.
  - REDIRECT: `o_pc_valid=1` and `o_pc_new={hi_q,lo_q}`. For RTI, also `o_flags_valid=1`, `o_flags=hi_q[FLAG_LSB+2:FLAG_LSB]`, and `o_pc_new` bits [2*DATA_W-1:DATA_W+FLAG_LSB] are forced to 0. Next state is IDLE.
- `o_busy = (state != IDLE)`.
- `o_stall = o_busy | i_ret | i_rti`. It is combinational, so the request cycle itself stalls.
- Requests arriving while busy are ignored; the pipeline cannot legally issue one because of the stall.
- `o_pc_new`/`o_flags` hold their last values outside REDIRECT. Only the strobes qualify them.
- Reset, asynchronous, including mid-sequence:
  - State goes to IDLE; `lo_q`, `hi_q`, `is_rti` go to 0.
  - All outputs go to 0.
  - SP is not restored by this unit; a partial pop stays committed.

## Timing
- Request in cycle T0; POP_LO in T1; POP_HI in T2; REDIRECT in T3. With no hold, `o_pc_valid` arrives 3 cycles after the request.
- Each cycle of `i_hold` during POP_LO or POP_HI adds one cycle. No pop and no capture happen in held cycles.
- Exactly one `o_pop` pulse per frame word. Exactly two pops per sequence.
- The unit can accept a new request in the cycle after REDIRECT.

## Configuration
- `PC_FRAME_FLAG_RESTORE_EN` defined:
  - RTI restores flags as described.
  - High-word flag bits are masked out of `o_pc_new`.
- `PC_FRAME_FLAG_RESTORE_EN` not defined:
  - `i_rti` behaves exactly as `i_ret`.
  - `o_flags_valid` and `o_flags` are tied to 0.
  - `o_pc_new` is always the full `{hi_q,lo_q}`.

## Structure
- Shared package holds:
  - The state enum (IDLE, POP_LO, POP_HI, REDIRECT).
  - The frame constants `FLAG_LSB`, the flag ordering {C,N,Z}, and the word order (high pushed first).
  - The execute-memory stage's push path imports the same constants.
- No sub-module: the FSM, capture registers and output muxing form one module.

## Test plan
- RET, no hold; memory returns lo=0x1234 in T1, hi=0x0001 in T2 -> `o_pc_valid` in T3 with 0x00011234, `o_flags_valid=0`, two `o_pop` pulses, `o_stall` high T0–T3.
- RTI with macro defined; lo=0x0100, hi=0xA005 -> `o_pc_new=0x00050100`, `o_flags=3'b101`, both strobes in T3.
- RTI without macro, same data -> `o_pc_new=0xA0050100`, `o_flags_valid=0`.
- RET with `i_hold` high in T1–T2 -> no `o_pop` in T1–T2; low captured in T3, high in T4, redirect in T5.
- `i_ret` and `i_rti` high together -> treated as RTI; a second `i_ret` during POP_HI is ignored (still exactly two pops).
- `i_reset` low during POP_HI -> all outputs 0 immediately; after release, a new RET completes normally from IDLE with fresh data.
